// File: rtl/coin_accumulator.sv
// coin_accumulator: running credit register fed by coin insertions and
// vend-controller deductions, with overflow/reject signalling toward the
// amount representation stage.
// Optional feature macro: COIN_SATURATE_EN (an overflowing coin clamps the
// credit at MAX_AMOUNT instead of being returned).
module coin_accumulator #(
    parameter int unsigned WIDTH      = 5,
    parameter int unsigned MAX_AMOUNT = 31
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             coin_valid,
    input  logic [1:0]       coin_sel,
    output logic             coin_ready,
    input  logic             clear,
    input  logic             deduct_valid,
    input  logic [WIDTH-1:0] deduct_amount,
    output logic             deduct_done,
    output logic             deduct_err,
    output logic [WIDTH-1:0] amount,
    output logic             overflow,
    output logic             coin_reject,
    output logic [1:0]       state
);

    localparam int unsigned SUM_W = WIDTH + 1;
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_AMOUNT);
    localparam logic [SUM_W-1:0] MAX_SUM = SUM_W'(MAX_AMOUNT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_CREDIT = 2'b01,
        ST_FULL   = 2'b10
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] amount_d;
    logic [SUM_W-1:0] coin_value;
    logic [SUM_W-1:0] sum;
    logic             done_d;
    logic             err_d;
    logic             overflow_d;
    logic             reject_d;

    assign state = state_q;

    // A coin may only be taken when no higher-priority request is present and credit is not full
    assign coin_ready = !clear && !deduct_valid && (state_q != ST_FULL);

    // Decode the coin denomination in NIS
    always_comb begin
        coin_value = SUM_W'(1);
        case (coin_sel)
            2'b00:   coin_value = SUM_W'(1);
            2'b01:   coin_value = SUM_W'(2);
            2'b10:   coin_value = SUM_W'(5);
            default: coin_value = SUM_W'(10);
        endcase
    end

    // One bit wider than the register so an overflowing coin is detectable
    assign sum = SUM_W'(amount) + coin_value;

    // Next credit and event pulses: clear beats deduct beats coin
    always_comb begin
        amount_d   = amount;
        done_d     = 1'b0;
        err_d      = 1'b0;
        overflow_d = 1'b0;
        reject_d   = 1'b0;
        if (clear) begin
            amount_d = '0;
        end else if (deduct_valid) begin
            if (deduct_amount <= amount) begin
                amount_d = amount - deduct_amount;
                done_d   = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else if (coin_valid && coin_ready) begin
            if (sum <= MAX_SUM) begin
                amount_d = sum[WIDTH-1:0];
            end else begin
                overflow_d = 1'b1;
`ifdef COIN_SATURATE_EN
                amount_d = MAX_VAL;
`else
                reject_d = 1'b1;
`endif
            end
        end
    end

    // State classification of the credit that will be stored on this edge
    always_comb begin
        state_d = ST_CREDIT;
        if (amount_d == '0) begin
            state_d = ST_IDLE;
        end else if (amount_d == MAX_VAL) begin
            state_d = ST_FULL;
        end
    end

    // Credit, state and one-cycle pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            amount      <= '0;
            state_q     <= ST_IDLE;
            deduct_done <= 1'b0;
            deduct_err  <= 1'b0;
            overflow    <= 1'b0;
            coin_reject <= 1'b0;
        end else begin
            amount      <= amount_d;
            state_q     <= state_d;
            deduct_done <= done_d;
            deduct_err  <= err_d;
            overflow    <= overflow_d;
            coin_reject <= reject_d;
        end
    end

endmodule

// File: tb/tb_coin_accumulator.sv
// Directed self-checking bench for coin_accumulator.
module tb_coin_accumulator;

    localparam int unsigned WIDTH = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             coin_valid;
    logic [1:0]       coin_sel;
    logic             coin_ready;
    logic             clear;
    logic             deduct_valid;
    logic [WIDTH-1:0] deduct_amount;
    logic             deduct_done;
    logic             deduct_err;
    logic [WIDTH-1:0] amount;
    logic             overflow;
    logic             coin_reject;
    logic [1:0]       state;

    int n_cmp = 0;
    int n_bad = 0;

    coin_accumulator #(.WIDTH(WIDTH), .MAX_AMOUNT(31)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .coin_valid    (coin_valid),
        .coin_sel      (coin_sel),
        .coin_ready    (coin_ready),
        .clear         (clear),
        .deduct_valid  (deduct_valid),
        .deduct_amount (deduct_amount),
        .deduct_done   (deduct_done),
        .deduct_err    (deduct_err),
        .amount        (amount),
        .overflow      (overflow),
        .coin_reject   (coin_reject),
        .state         (state)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle so registered outputs can be sampled
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_coin(input logic [1:0] sel);
        coin_valid = 1'b1;
        coin_sel   = sel;
        step();
        coin_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic do_deduct(input logic [WIDTH-1:0] amt);
        deduct_valid  = 1'b1;
        deduct_amount = amt;
        step();
        deduct_valid  = 1'b0;
        deduct_amount = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if (amount !== 5'd0 || state !== 2'b00 || coin_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_state: amount=%0d state=%0d ready=%0b, required 0/0/1", amount, state, coin_ready);
        end
        n_cmp++;
        if ({deduct_done, deduct_err, overflow, coin_reject} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_pulses: got %b, required 0000", {deduct_done, deduct_err, overflow, coin_reject});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_coin_sequence();
        logic [1:0] sels [6];
        int         exp_amt [6];
        sels    = '{2'b11, 2'b11, 2'b10, 2'b01, 2'b01, 2'b01};
        exp_amt = '{10, 20, 25, 27, 29, 31};
        for (int i = 0; i < 6; i++) begin
            coin_valid = 1'b1;
            coin_sel   = sels[i];
            step();
            n_cmp++;
            if (amount !== WIDTH'(exp_amt[i])) begin
                n_bad++;
                $display("FAIL coin_seq[%0d]: amount=%0d, required %0d", i, amount, exp_amt[i]);
            end
        end
        coin_valid = 1'b0;
        n_cmp++;
        if (state !== 2'b10 || coin_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL full_state: state=%0d ready=%0b, required 2/0", state, coin_ready);
        end
        put_coin(2'b00);
        n_cmp++;
        if (amount !== 5'd31 || overflow !== 1'b0 || coin_reject !== 1'b0 || state !== 2'b10) begin
            n_bad++;
            $display("FAIL full_ignore: amount=%0d ovf=%0b rej=%0b state=%0d, required 31/0/0/2",
                     amount, overflow, coin_reject, state);
        end
        do_deduct(5'd1);
        n_cmp++;
        if (amount !== 5'd30 || state !== 2'b01 || deduct_done !== 1'b1) begin
            n_bad++;
            $display("FAIL leave_full: amount=%0d state=%0d done=%0b, required 30/1/1", amount, state, deduct_done);
        end
    endtask

    task automatic test_overflow();
        do_clear();
        put_coin(2'b11);
        put_coin(2'b11);
        put_coin(2'b10);
        put_coin(2'b11);
`ifdef COIN_SATURATE_EN
        n_cmp++;
        if (amount !== 5'd31 || overflow !== 1'b1 || coin_reject !== 1'b0 || state !== 2'b10) begin
            n_bad++;
            $display("FAIL overflow_sat: amount=%0d ovf=%0b rej=%0b state=%0d, required 31/1/0/2",
                     amount, overflow, coin_reject, state);
        end
`else
        n_cmp++;
        if (amount !== 5'd25 || overflow !== 1'b1 || coin_reject !== 1'b1) begin
            n_bad++;
            $display("FAIL overflow_rej: amount=%0d ovf=%0b rej=%0b, required 25/1/1", amount, overflow, coin_reject);
        end
`endif
        step();
        n_cmp++;
        if (overflow !== 1'b0 || coin_reject !== 1'b0) begin
            n_bad++;
            $display("FAIL overflow_1cyc: ovf=%0b rej=%0b, required 0/0", overflow, coin_reject);
        end
    endtask

    task automatic test_boundary();
        do_clear();
        put_coin(2'b11);
        put_coin(2'b11);
        put_coin(2'b11);
        put_coin(2'b00);
        n_cmp++;
        if (amount !== 5'd31 || state !== 2'b10 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL b30_plus1: amount=%0d state=%0d ovf=%0b, required 31/2/0", amount, state, overflow);
        end
        do_clear();
        put_coin(2'b11);
        put_coin(2'b11);
        put_coin(2'b11);
        put_coin(2'b01);
`ifdef COIN_SATURATE_EN
        n_cmp++;
        if (amount !== 5'd31 || overflow !== 1'b1 || coin_reject !== 1'b0) begin
            n_bad++;
            $display("FAIL b30_plus2: amount=%0d ovf=%0b rej=%0b, required 31/1/0", amount, overflow, coin_reject);
        end
`else
        n_cmp++;
        if (amount !== 5'd30 || overflow !== 1'b1 || coin_reject !== 1'b1 || state !== 2'b01) begin
            n_bad++;
            $display("FAIL b30_plus2: amount=%0d ovf=%0b rej=%0b state=%0d, required 30/1/1/1",
                     amount, overflow, coin_reject, state);
        end
`endif
    endtask

    task automatic test_deduct();
        do_clear();
        put_coin(2'b11);
        put_coin(2'b10);
        do_deduct(5'd9);
        n_cmp++;
        if (amount !== 5'd6 || deduct_done !== 1'b1 || deduct_err !== 1'b0 || state !== 2'b01) begin
            n_bad++;
            $display("FAIL deduct_ok: amount=%0d done=%0b err=%0b state=%0d, required 6/1/0/1",
                     amount, deduct_done, deduct_err, state);
        end
        do_deduct(5'd7);
        n_cmp++;
        if (amount !== 5'd6 || deduct_done !== 1'b0 || deduct_err !== 1'b1) begin
            n_bad++;
            $display("FAIL deduct_err: amount=%0d done=%0b err=%0b, required 6/0/1", amount, deduct_done, deduct_err);
        end
        do_deduct(5'd0);
        n_cmp++;
        if (amount !== 5'd6 || deduct_done !== 1'b1 || deduct_err !== 1'b0) begin
            n_bad++;
            $display("FAIL deduct_zero: amount=%0d done=%0b err=%0b, required 6/1/0", amount, deduct_done, deduct_err);
        end
        step();
        n_cmp++;
        if (deduct_done !== 1'b0 || deduct_err !== 1'b0) begin
            n_bad++;
            $display("FAIL deduct_1cyc: done=%0b err=%0b, required 0/0", deduct_done, deduct_err);
        end
    endtask

    task automatic test_priority();
        do_clear();
        put_coin(2'b11);
        put_coin(2'b11);
        clear         = 1'b1;
        deduct_valid  = 1'b1;
        deduct_amount = 5'd5;
        coin_valid    = 1'b1;
        coin_sel      = 2'b01;
        #1;
        n_cmp++;
        if (coin_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL prio_ready: ready=%0b, required 0", coin_ready);
        end
        step();
        clear        = 1'b0;
        deduct_valid = 1'b0;
        coin_valid   = 1'b0;
        n_cmp++;
        if (amount !== 5'd0 || state !== 2'b00 || deduct_done !== 1'b0 || deduct_err !== 1'b0) begin
            n_bad++;
            $display("FAIL prio_clear: amount=%0d state=%0d done=%0b err=%0b, required 0/0/0/0",
                     amount, state, deduct_done, deduct_err);
        end
    endtask

    task automatic test_exact_deduct();
        put_coin(2'b10);
        put_coin(2'b01);
        do_deduct(5'd7);
        n_cmp++;
        if (amount !== 5'd0 || state !== 2'b00 || deduct_done !== 1'b1) begin
            n_bad++;
            $display("FAIL exact_deduct: amount=%0d state=%0d done=%0b, required 0/0/1", amount, state, deduct_done);
        end
        put_coin(2'b00);
        n_cmp++;
        if (amount !== 5'd1 || state !== 2'b01) begin
            n_bad++;
            $display("FAIL after_exact: amount=%0d state=%0d, required 1/1", amount, state);
        end
    endtask

    task automatic test_mid_reset();
        do_clear();
        put_coin(2'b11);
        put_coin(2'b01);
        do_deduct(5'd20);
        n_cmp++;
        if (amount !== 5'd12 || deduct_err !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset: amount=%0d err=%0b, required 12/1", amount, deduct_err);
        end
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if (amount !== 5'd0 || state !== 2'b00 || coin_ready !== 1'b1 ||
            {deduct_done, deduct_err, overflow, coin_reject} !== 4'b0000) begin
            n_bad++;
            $display("FAIL mid_reset: amount=%0d state=%0d ready=%0b pulses=%b, required 0/0/1/0000",
                     amount, state, coin_ready, {deduct_done, deduct_err, overflow, coin_reject});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        coin_valid    = 1'b0;
        coin_sel      = 2'b00;
        clear         = 1'b0;
        deduct_valid  = 1'b0;
        deduct_amount = '0;
        test_reset();
        test_coin_sequence();
        test_overflow();
        test_boundary();
        test_deduct();
        test_priority();
        test_exact_deduct();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/coin_accumulator.md
Name: coin_accumulator

Overview:
Sequential credit register that sits directly upstream of the 5-bit amount representation stage. It accepts coin insertions and deductions from the vend controller, and keeps the running credit in a 5-bit register (0..31 NIS). It drives the stored amount and an overflow indication that the downstream representation/display stage consumes.

Parameters:
WIDTH, 5, width of the credit register and of the amount/deduct buses
MAX_AMOUNT, 31, largest credit that may be held; must be <= 2**WIDTH-1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
coin_valid  input  1  coin present this cycle
coin_sel  input  2  coin value code: 00=1 NIS, 01=2 NIS, 10=5 NIS, 11=10 NIS
coin_ready  output  1  accumulator can take a coin this cycle
clear  input  1  refund/cancel; zero the credit
deduct_valid  input  1  vend controller requests a deduction
deduct_amount  input  WIDTH  price to deduct
deduct_done  output  1  one-cycle pulse: deduction applied
deduct_err  output  1  one-cycle pulse: deduction refused, insufficient credit
amount  output  WIDTH  current registered credit
overflow  output  1  one-cycle pulse: a coin would have exceeded MAX_AMOUNT
coin_reject  output  1  one-cycle pulse: the accepted coin was returned
state  output  2  00=IDLE, 01=CREDIT, 10=FULL

Behaviour:
- Reset (async, rst_n=0): amount=0, state=IDLE, and every pulse output is 0. coin_ready follows from state after reset, so it reads 1.
- coin_ready = !clear && !deduct_valid && state!=FULL. This is combinational.
- Coin handshake: a coin is taken only on a cycle where coin_valid && coin_ready. coin_valid while coin_ready=0 is ignored with no pulse; the source holds or retries.
- Sum is computed at WIDTH+1 bits: sum = amount + value(coin_sel).
  - If sum <= MAX_AMOUNT: amount <= sum on the next edge (latency 1).
  - Else: amount is unchanged, and overflow and coin_reject each pulse high for exactly one cycle, on the cycle after the handshake.
- Priority per cycle, highest first: clear, then deduct, then coin.
  - clear: amount <= 0 next edge. A simultaneous deduct_valid is dropped with no done/err pulse.
  - deduct: if deduct_amount <= amount, then amount <= amount - deduct_amount and deduct_done pulses. Otherwise amount is unchanged and deduct_err pulses. Subtraction never wraps.
  - A coin offered in a cycle with clear or deduct_valid is not accepted, because coin_ready=0.
- All pulse outputs are registered, are asserted on the cycle after the event, and are otherwise 0.
- State transitions are evaluated on the new amount, each edge:
  - IDLE: amount==0.
  - CREDIT: 0<amount<MAX_AMOUNT.
  - FULL: amount==MAX_AMOUNT. No coins are accepted; clear or deduct leaves FULL.
- Boundaries:
  - amount=30 + 1 NIS coin gives 31 and FULL.
  - amount=30 + 2 NIS coin is rejected with overflow.
  - deduct_amount=0 pulses deduct_done with amount unchanged.
  - deduct_amount==amount gives 0 and IDLE.
- Reset asserted mid-operation clears everything immediately. Any in-flight pulse is lost.

Optional Feature:
COIN_SATURATE_EN
- Defined: an overflowing coin is kept rather than returned. amount <= MAX_AMOUNT, overflow pulses, and coin_reject stays 0. The excess credit is forfeited.
- Undefined: reject behaviour as specified above. amount is unchanged, and overflow and coin_reject both pulse.

Test Plan:
- Reset: hold rst_n=0 mid-sequence with amount=12 -> amount=0, state=IDLE, coin_ready=1, all pulses 0, with no clock edge required.
- Coins 10, 10, 5, 2, 2, 2 (one per cycle) -> amount steps 10, 20, 25, 27, 29, 31. state=FULL after the last coin; coin_ready=0 and a further coin is ignored.
- amount=25, insert 10 -> overflow=1 and coin_reject=1 for one cycle, amount stays 25. With COIN_SATURATE_EN: amount=31, coin_reject=0.
- amount=15: deduct 9 -> deduct_done, amount=6. Then deduct 7 -> deduct_err, amount stays 6.
- amount=20: clear, deduct_valid(5) and coin_valid(2) all in the same cycle -> amount=0, IDLE, no done/err pulse, coin not taken.
- amount=7: deduct_amount=7 -> amount=0, state IDLE. Then a 1 NIS coin -> amount=1, CREDIT.
